// File: rtl/demux1x8_buffered.sv
// 1-to-8 demultiplexer with a one-entry valid/ready holding register per channel.
// Broadcast mode loads every channel with the same word in a single accept.
module demux1x8_buffered #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_data,
    input  logic [2:0]     in_sel,
    input  logic           in_bcast,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [8*N-1:0] out_data,
    output logic [7:0]     out_valid,
    input  logic [7:0]     out_ready,
    output logic [15:0]    word_count
);

    logic [7:0] free_p0;
    logic [7:0] load_p0;
    logic       accept_p0;

    // p0: a channel is free when empty or draining this cycle, so it can refill back-to-back
    always_comb begin
        free_p0   = ~out_valid | out_ready;
        in_ready  = 1'b0;
        if (!rst) begin
            in_ready = in_bcast ? (&free_p0) : free_p0[in_sel];
        end
        accept_p0 = in_valid & in_ready;
        load_p0   = 8'h00;
        if (accept_p0) begin
            load_p0 = in_bcast ? 8'hFF : (8'h01 << in_sel);
        end
    end

    // p1: holding registers; a reload takes priority over a drain on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 8'h00;
            word_count <= 16'h0000;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (load_p0[k]) begin
                    out_data[k*N +: N] <= in_data;
                    out_valid[k]       <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k]       <= 1'b0;
                end
            end
            if (accept_p0) begin
                word_count <= word_count + 16'd1;
            end
        end
    end

endmodule
